// File: rtl/regset_ctrl_pkg.sv
// regset_ctrl_pkg: shared widths, state encoding and constants for the register-set controller
package regset_ctrl_pkg;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;
  localparam int X0_ADDR = 0;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/regset_fwd.sv
// regset_fwd: registered write/read hit compare and read-data mux for one storage read port
module regset_fwd import regset_ctrl_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              wg,
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd_in,
  input  logic              rg_in,
  output logic [DATA_W-1:0] rd,
  output logic              rg
);
  logic              hit;
  logic [DATA_W-1:0] fd;
  logic              fg;
  logic [ADDR_W-1:0] ra_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit  <= 1'b0;
      fd   <= '0;
      fg   <= 1'b0;
      ra_q <= '0;
    end else begin
      hit  <= we && wa == ra;
      fd   <= wd;
      fg   <= wg;
      ra_q <= ra;
    end
  end
  always_comb begin
    rd = ra_q == ADDR_W'(X0_ADDR) ? '0 : hit ? fd : rd_in;
    rg = ra_q == ADDR_W'(X0_ADDR) ? 1'b0 : hit ? fg : rg_in;
  end
endmodule

// File: rtl/regset_ctrl.sv
// regset_ctrl: clears, forwards and arbitrates core/debug access to the register storage
module regset_ctrl import regset_ctrl_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              busy,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_wa,
  input  logic [DATA_W-1:0] core_wd,
  input  logic              core_wg,
  input  logic [ADDR_W-1:0] core_ra1,
  input  logic [ADDR_W-1:0] core_ra2,
  input  logic              core_re2,
  output logic [DATA_W-1:0] rd1,
  output logic              rg1,
  output logic [DATA_W-1:0] rd2,
  output logic              rg2,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              rs_we,
  output logic [ADDR_W-1:0] rs_wa,
  output logic [DATA_W-1:0] rs_wd,
  output logic              rs_wg,
  output logic [ADDR_W-1:0] rs_ra1,
  output logic [ADDR_W-1:0] rs_ra2,
  input  logic [DATA_W-1:0] rs_rd1,
  input  logic              rs_rg1,
  input  logic [DATA_W-1:0] rs_rd2,
  input  logic              rs_rg2
);
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              dbg_wr_gnt;
  logic              dbg_rd_gnt;
  logic              rd_ack;
  logic [DATA_W-1:0] hold;
  always_comb begin
    busy       = state == INIT;
    dbg_wr_gnt = !busy && dbg_req && dbg_we && !dbg_ack && !core_we;
    dbg_rd_gnt = !busy && dbg_req && !dbg_we && !dbg_ack && !core_re2;
    rs_wa      = busy ? cnt : core_we ? core_wa : dbg_addr;
    rs_wd      = busy ? '0 : core_we ? core_wd : dbg_wdata;
    rs_wg      = !busy && core_we && core_wg;
    rs_we      = busy || ((core_we || dbg_wr_gnt) && rs_wa != ADDR_W'(X0_ADDR));
    rs_ra1     = core_ra1;
    rs_ra2     = dbg_rd_gnt ? dbg_addr : core_ra2;
    dbg_rdata  = rd_ack ? rd2 : hold;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= INIT;
      cnt     <= '0;
      dbg_ack <= 1'b0;
      rd_ack  <= 1'b0;
      hold    <= '0;
    end else begin
      cnt     <= busy ? cnt + 1'b1 : cnt;
      state   <= busy && cnt == '1 ? RUN : state;
      dbg_ack <= dbg_wr_gnt || dbg_rd_gnt;
      rd_ack  <= dbg_rd_gnt;
      hold    <= dbg_rdata;
    end
  end
  regset_fwd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd1 (
    .clk(clk), .rstn(rstn), .we(rs_we), .wa(rs_wa), .wd(rs_wd), .wg(rs_wg),
    .ra(rs_ra1), .rd_in(rs_rd1), .rg_in(rs_rg1), .rd(rd1), .rg(rg1)
  );
  regset_fwd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd2 (
    .clk(clk), .rstn(rstn), .we(rs_we), .wa(rs_wa), .wd(rs_wd), .wg(rs_wg),
    .ra(rs_ra2), .rd_in(rs_rd2), .rg_in(rs_rg2), .rd(rd2), .rg(rg2)
  );
endmodule

// File: tb/tb_regset_ctrl.sv
// tb_regset_ctrl: table, directed and randomized checks of regset_ctrl against a register-file model
module tb_regset_ctrl;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int N = 64;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic busy, core_we, core_wg, core_re2, rg1, rg2, dbg_req, dbg_we, dbg_ack;
  logic rs_we, rs_wg, rs_rg1, rs_rg2;
  logic [AW-1:0] core_wa, core_ra1, core_ra2, dbg_addr, rs_wa, rs_ra1, rs_ra2;
  logic [DW-1:0] core_wd, rd1, rd2, dbg_wdata, dbg_rdata, rs_wd, rs_rd1, rs_rd2;
  logic [DW:0] mem [N];
  logic [DW:0] regs [N];
  int nchk = 0;
  int nfail = 0;
  always #5 clk = ~clk;
  regset_ctrl dut (
    .clk(clk), .rstn(rstn), .busy(busy),
    .core_we(core_we), .core_wa(core_wa), .core_wd(core_wd), .core_wg(core_wg),
    .core_ra1(core_ra1), .core_ra2(core_ra2), .core_re2(core_re2),
    .rd1(rd1), .rg1(rg1), .rd2(rd2), .rg2(rg2),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rs_we(rs_we), .rs_wa(rs_wa), .rs_wd(rs_wd), .rs_wg(rs_wg),
    .rs_ra1(rs_ra1), .rs_ra2(rs_ra2),
    .rs_rd1(rs_rd1), .rs_rg1(rs_rg1), .rs_rd2(rs_rd2), .rs_rg2(rs_rg2)
  );
  always @(posedge clk) begin
    {rs_rg1, rs_rd1} <= mem[rs_ra1];
    {rs_rg2, rs_rd2} <= mem[rs_ra2];
    if (rs_we) mem[rs_wa] <= {rs_wg, rs_wd};
  end
  typedef struct {
    logic cwe; logic [AW-1:0] cwa; logic [DW-1:0] cwd; logic cwg; logic cre2; logic [AW-1:0] cra2;
    logic dreq; logic dwe; logic [AW-1:0] dad; logic [DW-1:0] dwd;
    logic ewe; logic [AW-1:0] ewa; logic [DW-1:0] ewd; logic ewg; logic [AW-1:0] era2;
  } vec_t;
  vec_t tv [8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    core_we = 1'b0;
    core_wg = 1'b0;
    core_re2 = 1'b0;
    dbg_req = 1'b0;
    dbg_we = 1'b0;
  endtask
  task automatic sweep;
    for (int i = 0; i < N; i++) begin
      chk("init_sweep", 64'({busy, rs_we, rs_wa, rs_wd, rs_wg, dbg_ack}),
          64'({1'b1, 1'b1, AW'(i), 32'h0, 1'b0, 1'b0}));
      tick;
    end
    chk("busy_after_sweep", 64'(busy), 64'(0));
  endtask
  initial begin
    logic [DW:0] e1, e2;
    logic [DW-1:0] e_rdata;
    logic [AW-1:0] a2;
    logic e_ack, ev, pend, wgnt, rgnt, drop;
    for (int i = 0; i < N; i++) mem[i] = {1'($urandom), 32'($urandom)};
    idle;
    core_wa = '0; core_wd = '0; core_ra1 = '0; core_ra2 = '0; dbg_addr = '0; dbg_wdata = '0;
    #2 rstn = 1'b0;
    #1;
    chk("reset_state", 64'({busy, dbg_ack, dbg_rdata}), 64'({1'b1, 1'b0, 32'h0}));
    chk("reset_rd", 64'({rg1, rd1, rg2, rd2}), 64'(0));
    tick;
    tick;
    core_we = 1'b1; core_wa = 6'd5; core_wd = 32'hFFFF_FFFF; core_wg = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd3; dbg_wdata = 32'h1;
    rstn = 1'b1;
    sweep;
    idle;
    for (int i = 0; i < N; i++) begin
      core_ra1 = AW'(i);
      core_ra2 = AW'(N - 1 - i);
      core_re2 = 1'b1;
      tick;
      chk("clear_rd1", 64'({rg1, rd1}), 64'(0));
      chk("clear_rd2", 64'({rg2, rd2}), 64'(0));
    end
    idle;
    tv[0] = '{1'b1, 6'd10, 32'hA5A5_0001, 1'b1, 1'b1, 6'd3, 1'b1, 1'b1, 6'd12, 32'h0000_000B, 1'b1, 6'd10, 32'hA5A5_0001, 1'b1, 6'd3};
    tv[1] = '{1'b0, 6'd10, 32'h0, 1'b0, 1'b0, 6'd4, 1'b1, 1'b1, 6'd12, 32'h0000_00BB, 1'b1, 6'd12, 32'h0000_00BB, 1'b0, 6'd4};
    tv[2] = '{1'b1, 6'd0, 32'h0000_1234, 1'b1, 1'b0, 6'd5, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd5};
    tv[3] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd6, 1'b1, 1'b1, 6'd0, 32'h0000_0077, 1'b0, 6'd0, 32'h0, 1'b0, 6'd6};
    tv[4] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd4, 1'b1, 1'b0, 6'd20, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd20};
    tv[5] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 6'd4, 1'b1, 1'b0, 6'd20, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd4};
    tv[6] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd33, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd33};
    tv[7] = '{1'b1, 6'd63, 32'hFFFF_FFFF, 1'b0, 1'b0, 6'd2, 1'b1, 1'b0, 6'd9, 32'h0, 1'b1, 6'd63, 32'hFFFF_FFFF, 1'b0, 6'd9};
    for (int i = 0; i < 8; i++) begin
      core_we = tv[i].cwe; core_wa = tv[i].cwa; core_wd = tv[i].cwd; core_wg = tv[i].cwg;
      core_re2 = tv[i].cre2; core_ra2 = tv[i].cra2;
      dbg_req = tv[i].dreq; dbg_we = tv[i].dwe; dbg_addr = tv[i].dad; dbg_wdata = tv[i].dwd;
      #1;
      chk("tbl_we", 64'(rs_we), 64'(tv[i].ewe));
      if (tv[i].ewe) chk("tbl_wdata", 64'({rs_wa, rs_wd, rs_wg}), 64'({tv[i].ewa, tv[i].ewd, tv[i].ewg}));
      chk("tbl_ra2", 64'(rs_ra2), 64'(tv[i].era2));
      idle;
      tick;
    end
    core_we = 1'b1; core_wa = 6'd5; core_wd = 32'hDEAD_BEEF; core_wg = 1'b1; core_ra1 = 6'd5;
    tick;
    idle;
    chk("fwd_rd1", 64'({rg1, rd1}), 64'({1'b1, 32'hDEAD_BEEF}));
    tick;
    chk("stored_rd1", 64'({rg1, rd1}), 64'({1'b1, 32'hDEAD_BEEF}));
    core_we = 1'b1; core_wa = 6'd0; core_wd = 32'h0000_1234; core_wg = 1'b1;
    core_re2 = 1'b1; core_ra2 = 6'd0;
    #1;
    chk("x0_write_masked", 64'(rs_we), 64'(0));
    tick;
    idle;
    chk("x0_rd2", 64'({rg2, rd2}), 64'(0));
    core_we = 1'b1; core_wa = 6'd9; core_wd = 32'h99; core_wg = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd7; dbg_wdata = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dbgw_blocked", 64'({rs_wa, dbg_ack}), 64'({6'd9, 1'b0}));
      tick;
    end
    core_we = 1'b0;
    #1;
    chk("dbgw_grant", 64'({rs_we, rs_wa, rs_wd, rs_wg, dbg_ack}), 64'({1'b1, 6'd7, 32'h55, 1'b0, 1'b0}));
    tick;
    chk("dbgw_ack", 64'(dbg_ack), 64'(1));
    #1;
    chk("dbgw_no_regrant", 64'(rs_we), 64'(0));
    tick;
    dbg_req = 1'b0;
    chk("dbgw_ack_pulse", 64'(dbg_ack), 64'(0));
    core_ra1 = 6'd7;
    tick;
    chk("dbgw_readback", 64'({rg1, rd1}), 64'({1'b0, 32'h55}));
    core_re2 = 1'b1; core_ra2 = 6'd3;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd7;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("dbgr_blocked", 64'({rs_ra2, dbg_ack}), 64'({6'd3, 1'b0}));
      tick;
    end
    core_re2 = 1'b0;
    #1;
    chk("dbgr_grant", 64'(rs_ra2), 64'(7));
    tick;
    chk("dbgr_ack", 64'({dbg_ack, dbg_rdata}), 64'({1'b1, 32'h55}));
    #1;
    chk("dbgr_no_regrant", 64'(rs_ra2), 64'(3));
    tick;
    dbg_req = 1'b0;
    chk("dbgr_hold", 64'({dbg_ack, dbg_rdata}), 64'({1'b0, 32'h55}));
    tick;
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    for (int i = 0; i < 30; i++) tick;
    chk("midinit_count", 64'({busy, rs_wa}), 64'({1'b1, 6'd30}));
    rstn = 1'b0;
    #1;
    chk("midinit_reset", 64'({busy, rs_wa}), 64'({1'b1, 6'd0}));
    tick;
    rstn = 1'b1;
    sweep;
    for (int i = 0; i < N; i++) regs[i] = '0;
    e1 = '0; e2 = '0; e_rdata = '0; e_ack = 1'b0; ev = 1'b0; drop = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (ev) begin
        chk("rand_rd1", 64'({rg1, rd1}), 64'(e1));
        chk("rand_rd2", 64'({rg2, rd2}), 64'(e2));
        chk("rand_ack", 64'(dbg_ack), 64'(e_ack));
        chk("rand_rdata", 64'(dbg_rdata), 64'(e_rdata));
      end
      if (e_ack) begin
        dbg_req = 1'($urandom);
        drop = 1'b1;
      end else if (drop) begin
        dbg_req = 1'b0;
        drop = 1'b0;
      end else if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1'b1;
        dbg_we = 1'($urandom);
        dbg_addr = 6'($urandom_range(0, 15));
        dbg_wdata = 32'($urandom);
      end
      core_we = 1'($urandom);
      core_wa = 6'($urandom_range(0, 15));
      core_wd = 32'($urandom);
      core_wg = 1'($urandom);
      core_ra1 = 6'($urandom_range(0, 15));
      core_ra2 = 6'($urandom_range(0, 15));
      core_re2 = 1'($urandom);
      pend = dbg_req && !e_ack;
      wgnt = pend && dbg_we && !core_we;
      rgnt = pend && !dbg_we && !core_re2;
      if (core_we) begin
        if (core_wa != 0) regs[core_wa] = {core_wg, core_wd};
      end else if (wgnt && dbg_addr != 0) regs[dbg_addr] = {1'b0, dbg_wdata};
      e1 = core_ra1 == 0 ? '0 : regs[core_ra1];
      a2 = rgnt ? dbg_addr : core_ra2;
      e2 = a2 == 0 ? '0 : regs[a2];
      if (rgnt) e_rdata = e2[DW-1:0];
      e_ack = wgnt || rgnt;
      ev = 1'b1;
      tick;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/regset_ctrl.md
Name: regset_ctrl

Overview:
- Controller in front of the 64-entry, 33-bit register storage (32 data bits plus grubby bit). Storage has 6-bit addresses, two synchronous read ports, one write port, and is read-first on a same-address read/write.
- Clears all entries after reset, for targets whose BRAM has no preinit.
- Forwards same-cycle writes to both read ports and forces x0 to zero.
- Shares write port and read port 2 between the core and a debug requester.

Parameters:
- ADDR_W, 6, register address width; entry count is 2^ADDR_W.
- DATA_W, 32, register data width, excluding grubby bit.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- busy  out  1  high while clearing; core must stall
- core_we  in  1  core writeback enable
- core_wa  in  ADDR_W  core write address
- core_wd  in  DATA_W  core write data
- core_wg  in  1  core write grubby bit
- core_ra1  in  ADDR_W  core read address, port 1
- core_ra2  in  ADDR_W  core read address, port 2
- core_re2  in  1  core uses read port 2 this cycle
- rd1  out  DATA_W  read data, port 1 (1-cycle latency)
- rg1  out  1  read grubby, port 1
- rd2  out  DATA_W  read data, port 2
- rg2  out  1  read grubby, port 2
- dbg_req  in  1  debug request, held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data (grubby written as 0)
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  debug read data, valid with dbg_ack
- rs_we  out  1  storage write enable
- rs_wa  out  ADDR_W  storage write address
- rs_wd  out  DATA_W  storage write data
- rs_wg  out  1  storage write grubby bit
- rs_ra1  out  ADDR_W  storage read address, port 1
- rs_ra2  out  ADDR_W  storage read address, port 2
- rs_rd1  in  DATA_W  storage read data, port 1
- rs_rg1  in  1  storage read grubby, port 1
- rs_rd2  in  DATA_W  storage read data, port 2
- rs_rg2  in  1  storage read grubby, port 2

Behaviour:
- Reset values:
  - State INIT, clear counter 0, busy 1.
  - dbg_ack 0, dbg_rdata 0.
  - Forward-hit flags 0, forward data 0, registered read addresses 0.
- INIT state:
  - rs_we=1, rs_wa=counter, rs_wd=0, rs_wg=0.
  - Counter increments every clock.
  - The edge with counter=2^ADDR_W-1 writes the last entry and moves to RUN.
  - busy=1 throughout INIT (combinational from state). busy falls after the 64th rising edge following reset release.
  - Core write inputs are ignored; debug requests get no ack.
- Reset asserted mid-INIT or mid-RUN: immediate return to INIT with counter 0. The full sweep restarts.
- RUN write arbitration:
  - Core has fixed priority.
  - When core_we=1: rs_* carry core_wa/core_wd/core_wg.
  - Otherwise, a pending debug write (dbg_req & dbg_we & !dbg_ack) is granted: rs_wd=dbg_wdata, rs_wg=0.
  - Any write to address 0 is accepted but rs_we is masked to 0.
- RUN read port 2: a pending debug read (dbg_req & !dbg_we & !dbg_ack) is granted only when core_re2=0; then rs_ra2=dbg_addr, else rs_ra2=core_ra2.
- rs_ra1 = core_ra1 always.
- Debug handshake:
  - A grant in cycle t gives dbg_ack=1 in t+1; for reads, dbg_rdata = forwarded port-2 result.
  - No new grant is made while dbg_ack=1, so a held request is never served twice.
  - dbg_rdata holds its value until the next read ack.
  - The core can starve debug indefinitely; this is accepted.
- Forwarding, per read port p:
  - In cycle t, register hit_p = rs_we & (rs_wa == rs_ra_p), plus the written data and grubby.
  - In t+1: if the registered read address is 0, output 0/0; else if hit_p, output the forwarded value; else rs_rd_p/rs_rg_p.
  - A write and a read to the same address in one cycle therefore return the new value one cycle later.
- Read latency is 1 cycle for both ports in RUN. Read outputs during INIT are don't-care.

Decomposition:
- Shared package holds:
  - ADDR_W and DATA_W defaults
  - state encoding: INIT=1'b0, RUN=1'b1
  - the constant X0_ADDR=0
- One sub-module, regset_fwd: the per-port registered hit compare and output mux.
  - Instantiated twice, for ports 1 and 2.
  - Its ports: clk, rstn, we, wa, wd, wg, ra, rd_in, rg_in, rd, rg.

Test Plan:
- Release rstn -> busy=1 for exactly 64 cycles; rs_wa steps 0..63 with rs_wd=0, rs_wg=0; then busy=0 and every read returns 0.
- RUN, core_we=1, core_wa=5, core_wd=0xDEADBEEF, core_wg=1, core_ra1=5 in the same cycle -> next cycle rd1=0xDEADBEEF, rg1=1, although the storage returns the old value.
- Core write of 0x1234 to address 0, then core_ra2=0 -> rs_we=0 during that write, and rd2=0, rg2=0.
- dbg write addr 7, data 0x55 while core_we=1 for 3 cycles -> no write and no ack for 3 cycles; grant in cycle 4, dbg_ack in cycle 5; a later core read of 7 returns 0x55, rg=0.
- dbg read addr 7 with core_re2=1 for 2 cycles, then 0 -> rs_ra2=7 in cycle 3; dbg_ack=1 with dbg_rdata=0x55 in cycle 4; no second ack while dbg_req is held.
- Assert rstn=0 at counter=30 -> busy stays 1 and counter restarts at 0; the full 64-cycle sweep repeats.
